// File: rtl/sram_fifo_pkg.sv
// Shared constants and FSM encoding for the SRAM-backed multi-queue FIFO.
// The arbiter defaults its parameters from these values.
package sram_fifo_pkg;

    localparam int DEF_NUM_QUEUES      = 4;
    localparam int DEF_QUEUE_ID_WIDTH  = 2;
    localparam int DEF_OCC_WIDTH       = 18;
    localparam int DEF_QUEUE_SIZE      = 131072;
    localparam int DEF_FULL_MARGIN     = 5;
    localparam int DEF_MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sram_rw_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after ptr,
// wrapping around, wins.
module rr_pick
    import sram_fifo_pkg::*;
#(
    parameter int N   = DEF_NUM_QUEUES,
    parameter int IDW = DEF_QUEUE_ID_WIDTH
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic           valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // Offsets 1..N from ptr; offset N revisits ptr itself last.
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    grant[j] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Arbitrates 2-cycle write and read bursts between logical queues sharing one
// SRAM, tracking per-queue occupancy and in-flight reads.
module sram_rw_arbiter
    import sram_fifo_pkg::*;
#(
    parameter int NUM_QUEUES      = DEF_NUM_QUEUES,
    parameter int QUEUE_ID_WIDTH  = DEF_QUEUE_ID_WIDTH,
    parameter int OCC_WIDTH       = DEF_OCC_WIDTH,
    parameter int QUEUE_SIZE      = DEF_QUEUE_SIZE,
    parameter int FULL_MARGIN     = DEF_FULL_MARGIN,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_QUEUES-1:0]     wr_req,
    input  logic [NUM_QUEUES-1:0]     rd_ready,
    input  logic                      sram_write_full,
    input  logic                      sram_read_full,
    input  logic                      rd_return_valid,
    input  logic [QUEUE_ID_WIDTH-1:0] rd_return_qid,
    output logic [NUM_QUEUES-1:0]     wr_grant,
    output logic                      rd_issue_valid,
    output logic [QUEUE_ID_WIDTH-1:0] rd_issue_qid,
    output logic [NUM_QUEUES-1:0]     q_full,
    output logic [NUM_QUEUES-1:0]     q_empty,
    output logic                      err_underflow
);

    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCC_WIDTH-1:0]      FULL_LEVEL = OCC_WIDTH'(QUEUE_SIZE - FULL_MARGIN);
    localparam logic [OUT_WIDTH-1:0]      OUT_LIMIT  = OUT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [QUEUE_ID_WIDTH-1:0] PTR_RESET  = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);

    arb_state_t state;
    logic       half;
    logic       last_wr;

    logic [QUEUE_ID_WIDTH-1:0] wr_ptr;
    logic [QUEUE_ID_WIDTH-1:0] rd_ptr;

    logic [OCC_WIDTH-1:0] occ      [NUM_QUEUES];
    logic [OCC_WIDTH-1:0] occ_next [NUM_QUEUES];
    logic [OUT_WIDTH-1:0] outstanding [NUM_QUEUES];

    logic [NUM_QUEUES-1:0]     wr_elig;
    logic [NUM_QUEUES-1:0]     rd_elig;
    logic [NUM_QUEUES-1:0]     wr_onehot;
    logic [NUM_QUEUES-1:0]     rd_onehot;
    logic                      wr_any;
    logic                      rd_any;
    logic [QUEUE_ID_WIDTH-1:0] wr_idx;
    logic [QUEUE_ID_WIDTH-1:0] rd_idx;
    logic                      decide;
    logic                      choose_rd;
    logic                      choose_wr;
    logic                      underflow_hit;

    always_comb begin
        wr_elig = '0;
        rd_elig = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            wr_elig[q] = wr_req[q] && !q_full[q] && !sram_write_full;
            rd_elig[q] = (occ[q] != '0) && rd_ready[q]
                         && (outstanding[q] < OUT_LIMIT) && !sram_read_full;
        end
    end

    rr_pick #(
        .N   (NUM_QUEUES),
        .IDW (QUEUE_ID_WIDTH)
    ) u_wr_pick (
        .req   (wr_elig),
        .ptr   (wr_ptr),
        .grant (wr_onehot),
        .valid (wr_any)
    );

    rr_pick #(
        .N   (NUM_QUEUES),
        .IDW (QUEUE_ID_WIDTH)
    ) u_rd_pick (
        .req   (rd_elig),
        .ptr   (rd_ptr),
        .grant (rd_onehot),
        .valid (rd_any)
    );

    always_comb begin
        wr_idx = '0;
        rd_idx = '0;
        for (int j = 0; j < NUM_QUEUES; j++) begin
            if (wr_onehot[j]) wr_idx = QUEUE_ID_WIDTH'(j);
            if (rd_onehot[j]) rd_idx = QUEUE_ID_WIDTH'(j);
        end
    end

    // A new burst may start from IDLE or in the halfway cycle of the current one.
    // Reads take priority right after a write so neither direction starves.
    assign decide    = (state == ST_IDLE) || half;
    assign choose_rd = rd_any && (last_wr || !wr_any);
    assign choose_wr = wr_any && !choose_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            half           <= 1'b0;
            last_wr        <= 1'b0;
            wr_ptr         <= PTR_RESET;
            rd_ptr         <= PTR_RESET;
            wr_grant       <= '0;
            rd_issue_valid <= 1'b0;
            rd_issue_qid   <= '0;
        end else begin
            wr_grant       <= '0;
            rd_issue_valid <= 1'b0;
            rd_issue_qid   <= '0;
            if (decide) begin
                half <= 1'b0;
                if (choose_rd) begin
                    state          <= ST_RD_BURST;
                    rd_issue_valid <= 1'b1;
                    rd_issue_qid   <= rd_idx;
                    rd_ptr         <= rd_idx;
                    last_wr        <= 1'b0;
                end else if (choose_wr) begin
                    state    <= ST_WR_BURST;
                    wr_grant <= wr_onehot;
                    wr_ptr   <= wr_idx;
                    last_wr  <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                half <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            occ_next[q] = occ[q];
            if (wr_grant[q]) begin
                occ_next[q] = occ[q] + 1'b1;
            end else if (rd_issue_valid && (rd_issue_qid == QUEUE_ID_WIDTH'(q))) begin
                occ_next[q] = occ[q] - 1'b1;
            end
        end
    end

    always_comb begin
        underflow_hit = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (rd_return_valid && (rd_return_qid == QUEUE_ID_WIDTH'(q))
                && !(rd_issue_valid && (rd_issue_qid == QUEUE_ID_WIDTH'(q)))
                && (outstanding[q] == '0)) begin
                underflow_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                occ[q]         <= '0;
                outstanding[q] <= '0;
            end
            q_full        <= '0;
            q_empty       <= '1;
            err_underflow <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                occ[q]     <= occ_next[q];
                q_full[q]  <= (occ_next[q] >= FULL_LEVEL);
                q_empty[q] <= (occ_next[q] == '0);
                // A simultaneous issue and return cancel out.
                if (rd_issue_valid && (rd_issue_qid == QUEUE_ID_WIDTH'(q))) begin
                    if (!(rd_return_valid && (rd_return_qid == QUEUE_ID_WIDTH'(q)))) begin
                        outstanding[q] <= outstanding[q] + 1'b1;
                    end
                end else if (rd_return_valid && (rd_return_qid == QUEUE_ID_WIDTH'(q))
                             && (outstanding[q] != '0)) begin
                    outstanding[q] <= outstanding[q] - 1'b1;
                end
            end
            if (underflow_hit) err_underflow <= 1'b1;
        end
    end

endmodule
